// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, data-memory wait freezes,
// control-transfer flushes and sticky halt for the 5-stage core.
module hazard_ctrl #(
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_dREN,
  input  logic             ex_RegWr,
  input  logic [4:0]       ex_wsel,
  input  logic             ex_xfer,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_halt,
  output logic             pc_en,
  output logic             ifid_pause,
  output logic             ifid_flush,
  output logic             idex_dopause,
  output logic             idex_doflush,
  output logic             exmem_pause,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned BW = 2;

  typedef enum logic [1:0] {RUN, BUBBLE, MEMWAIT, HALTED} state_t;

  state_t        state, state_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic          memwait, loaduse;

  assign memwait = (mem_dREN | mem_dWEN) & ~dhit;
  assign loaduse = ex_dREN & ex_RegWr & (ex_wsel != 5'd0) &
                   ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));

  // State, bubble counter and registered halt flag
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
      bcnt  <= '0;
      halt  <= 1'b0;
    end else begin
      state <= state_n;
      bcnt  <= bcnt_n;
      halt  <= (state_n == HALTED);
    end
  end

  // Saturating count of cycles the PC is held outside of halt
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
    end else if (!pc_en && (state != HALTED) && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Next state and pipeline controls; priority halt > memwait > xfer > load-use
  always_comb begin
    state_n      = state;
    bcnt_n       = bcnt;
    pc_en        = 1'b1;
    ifid_pause   = 1'b0;
    ifid_flush   = 1'b0;
    idex_dopause = 1'b0;
    idex_doflush = 1'b0;
    exmem_pause  = 1'b0;

    if (state == HALTED) begin
      pc_en        = 1'b0;
      ifid_pause   = 1'b1;
      idex_dopause = 1'b1;
      exmem_pause  = 1'b1;
    end else if (mem_halt && !(state == MEMWAIT && memwait)) begin
      pc_en        = 1'b0;
      ifid_pause   = 1'b1;
      idex_dopause = 1'b1;
      exmem_pause  = 1'b1;
      state_n      = HALTED;
      bcnt_n       = '0;
    end else if (memwait) begin
      pc_en        = 1'b0;
      ifid_pause   = 1'b1;
      idex_dopause = 1'b1;
      exmem_pause  = 1'b1;
      state_n      = MEMWAIT;
      bcnt_n       = '0;
    end else if (ex_xfer) begin
      // Flush squashes any dependent instruction in ID, so it beats load-use
      ifid_flush   = 1'b1;
      idex_doflush = 1'b1;
      state_n      = RUN;
      bcnt_n       = '0;
    end else if (state == BUBBLE) begin
      pc_en        = 1'b0;
      ifid_pause   = 1'b1;
      idex_doflush = 1'b1;
      if (ihit) begin
        if ((32'(bcnt) + 32'd1) >= LOAD_BUBBLES) begin
          state_n = RUN;
          bcnt_n  = '0;
        end else begin
          bcnt_n  = bcnt + BW'(1);
        end
      end
    end else if (loaduse) begin
      pc_en        = 1'b0;
      ifid_pause   = 1'b1;
      idex_doflush = 1'b1;
      state_n      = RUN;
      if (ihit && (LOAD_BUBBLES > 1)) begin
        state_n = BUBBLE;
        bcnt_n  = BW'(1);
      end
    end else begin
      state_n = RUN;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl (LOAD_BUBBLES=1/CNT_W=16 and
// LOAD_BUBBLES=2/CNT_W=4 instances driven from the same inputs).
module tb_hazard_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       nRST;
  logic       ihit, dhit, id_uses_rt, ex_dREN, ex_RegWr, ex_xfer;
  logic       mem_dREN, mem_dWEN, mem_halt;
  logic [4:0] id_rs, id_rt, ex_wsel;

  logic        pc_en, ifid_pause, ifid_flush, idex_dopause, idex_doflush, exmem_pause, halt;
  logic [15:0] stall_cnt;
  logic        b_pc_en, b_ifid_pause, b_ifid_flush, b_idex_dopause, b_idex_doflush, b_exmem_pause, b_halt;
  logic [3:0]  b_stall_cnt;

  hazard_ctrl #(.LOAD_BUBBLES(1), .CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_dREN(ex_dREN), .ex_RegWr(ex_RegWr), .ex_wsel(ex_wsel),
    .ex_xfer(ex_xfer), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
    .pc_en(pc_en), .ifid_pause(ifid_pause), .ifid_flush(ifid_flush),
    .idex_dopause(idex_dopause), .idex_doflush(idex_doflush), .exmem_pause(exmem_pause),
    .halt(halt), .stall_cnt(stall_cnt));

  hazard_ctrl #(.LOAD_BUBBLES(2), .CNT_W(4)) dut2 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_dREN(ex_dREN), .ex_RegWr(ex_RegWr), .ex_wsel(ex_wsel),
    .ex_xfer(ex_xfer), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
    .pc_en(b_pc_en), .ifid_pause(b_ifid_pause), .ifid_flush(b_ifid_flush),
    .idex_dopause(b_idex_dopause), .idex_doflush(b_idex_doflush), .exmem_pause(b_exmem_pause),
    .halt(b_halt), .stall_cnt(b_stall_cnt));

  // Expected control vector order: {pc_en, ifid_pause, ifid_flush, idex_dopause, idex_doflush, exmem_pause, halt}
  localparam logic [6:0] O_IDLE = 7'b1000000;
  localparam logic [6:0] O_LU   = 7'b0100100;
  localparam logic [6:0] O_FRZ  = 7'b0101010;
  localparam logic [6:0] O_XF   = 7'b1010100;
  localparam logic [6:0] O_HLT  = 7'b0101011;

  typedef struct {
    logic       ihit, dhit;
    logic [4:0] rs, rt;
    logic       ur, ld, rw;
    logic [4:0] ws;
    logic       xf, mr, mw, mh;
    logic [6:0] exp;
    int unsigned cnt;
  } vec_t;

  vec_t tv[$];
  int   nvec = 0;
  int   nmis = 0;

  function automatic vec_t mk(input logic ih, input logic dh, input logic [4:0] rs, input logic [4:0] rt,
                              input logic ur, input logic ld, input logic rw, input logic [4:0] ws,
                              input logic xf, input logic mr, input logic mw, input logic mh,
                              input logic [6:0] exp, input int unsigned cnt);
    vec_t v;
    v.ihit = ih; v.dhit = dh; v.rs = rs; v.rt = rt; v.ur = ur; v.ld = ld; v.rw = rw;
    v.ws = ws; v.xf = xf; v.mr = mr; v.mw = mw; v.mh = mh; v.exp = exp; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ihit = v.ihit; dhit = v.dhit; id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.ur;
    ex_dREN = v.ld; ex_RegWr = v.rw; ex_wsel = v.ws; ex_xfer = v.xf;
    mem_dREN = v.mr; mem_dWEN = v.mw; mem_halt = v.mh;
  endtask

  // One cycle: drive after the falling edge, check mid-low-phase
  task automatic cyc(input vec_t v, input string nm, input bit second);
    @(negedge CLK);
    drive(v);
    #1;
    if (!second) begin
      chk({nm, " ctl"}, 32'({pc_en, ifid_pause, ifid_flush, idex_dopause, idex_doflush, exmem_pause, halt}), 32'(v.exp));
      chk({nm, " cnt"}, 32'(stall_cnt), v.cnt);
    end else begin
      chk({nm, " ctl"}, 32'({b_pc_en, b_ifid_pause, b_ifid_flush, b_idex_dopause, b_idex_doflush, b_exmem_pause, b_halt}), 32'(v.exp));
      chk({nm, " cnt"}, 32'(b_stall_cnt), v.cnt);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    drive(mk(1,0,0,0,0,0,0,0,0,0,0,0,O_IDLE,0));
    #2;
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0;
    drive(mk(1,0,0,0,0,0,0,0,0,0,0,0,O_IDLE,0));
    #2;
    chk("reset ctl", 32'({pc_en, ifid_pause, ifid_flush, idex_dopause, idex_doflush, exmem_pause, halt}), 32'(O_IDLE));
    chk("reset cnt", 32'(stall_cnt), 0);
    chk("reset2 ctl", 32'({b_pc_en, b_ifid_pause, b_ifid_flush, b_idex_dopause, b_idex_doflush, b_exmem_pause, b_halt}), 32'(O_IDLE));
    @(negedge CLK);
    nRST = 1'b1;

    //         ih dh rs rt ur ld rw ws xf mr mw mh  exp     cnt
    tv.push_back(mk(1,0, 0, 0,0,0,0, 0,0,0,0,0, O_IDLE, 0));  // idle
    tv.push_back(mk(1,0, 5, 0,0,1,1, 5,0,0,0,0, O_LU,   0));  // load-use on rs
    tv.push_back(mk(1,0, 0, 0,0,0,0, 0,0,0,0,0, O_IDLE, 1));  // released, one stall
    tv.push_back(mk(1,0, 0, 0,0,1,1, 0,0,0,0,0, O_IDLE, 1));  // r0 destination
    tv.push_back(mk(1,0, 3, 5,0,1,1, 5,0,0,0,0, O_IDLE, 1));  // rt match, rt unused
    tv.push_back(mk(1,0, 3, 5,1,1,1, 5,0,0,0,0, O_LU,   1));  // rt match, rt used
    tv.push_back(mk(1,0, 0, 0,0,0,0, 0,0,0,0,0, O_IDLE, 2));
    tv.push_back(mk(1,0, 5, 0,0,1,0, 5,0,0,0,0, O_IDLE, 2));  // load without RegWr
    for (int i = 0; i < 4; i++)
      tv.push_back(mk(1,0, 0, 0,0,0,0, 0,0,1,0,0, O_FRZ, 2 + i)); // load waiting in MEM
    tv.push_back(mk(1,1, 0, 0,0,0,0, 0,0,1,0,0, O_IDLE, 6));  // dhit releases same cycle
    tv.push_back(mk(1,0, 0, 0,0,0,0, 0,0,0,0,0, O_IDLE, 6));
    tv.push_back(mk(1,0, 5, 0,0,1,1, 5,1,0,0,0, O_XF,   6));  // xfer beats load-use
    tv.push_back(mk(1,0, 0, 0,0,0,0, 0,0,0,0,0, O_IDLE, 6));
    tv.push_back(mk(1,0, 5, 0,0,1,1, 5,0,0,1,0, O_FRZ,  6));  // memwait beats load-use
    tv.push_back(mk(1,1, 5, 0,0,1,1, 5,0,0,1,0, O_LU,   7));  // load-use after release
    tv.push_back(mk(1,0, 0, 0,0,0,0, 0,0,0,0,0, O_IDLE, 8));
    tv.push_back(mk(0,0, 7, 0,0,1,1, 7,0,0,0,0, O_LU,   8));  // no ihit: bubble held
    tv.push_back(mk(1,0, 7, 0,0,1,1, 7,0,0,0,0, O_LU,   9));
    tv.push_back(mk(1,0, 0, 0,0,0,0, 0,0,0,0,0, O_IDLE, 10));

    foreach (tv[i]) cyc(tv[i], $sformatf("vec%0d", i), 1'b0);

    // Halt: registered flag, full freeze, counter frozen, async reset exit
    cyc(mk(1,0,0,0,0,0,0,0,0,0,0,1, O_FRZ, 10), "halt_in", 1'b0);
    for (int i = 0; i < 20; i++)
      cyc(mk(1,0,0,0,0,0,0,0,0,0,0,0, O_HLT, 11), $sformatf("halted%0d", i), 1'b0);
    #1;
    nRST = 1'b0;
    #1;
    chk("halt_rst ctl", 32'({pc_en, ifid_pause, ifid_flush, idex_dopause, idex_doflush, exmem_pause, halt}), 32'(O_IDLE));
    chk("halt_rst cnt", 32'(stall_cnt), 0);
    @(negedge CLK);
    nRST = 1'b1;

    // Two-bubble instance: bubble counting, xfer preempt, 4-bit saturation
    do_reset();
    cyc(mk(1,0,5,0,0,1,1,5,0,0,0,0, O_LU,   0), "b2_lu",     1'b1);
    cyc(mk(0,0,0,0,0,0,0,0,0,0,0,0, O_LU,   1), "b2_noihit", 1'b1);
    cyc(mk(1,0,0,0,0,0,0,0,0,0,0,0, O_LU,   2), "b2_second", 1'b1);
    cyc(mk(1,0,0,0,0,0,0,0,0,0,0,0, O_IDLE, 3), "b2_done",   1'b1);
    cyc(mk(1,0,5,0,0,1,1,5,0,0,0,0, O_LU,   3), "b2_lu2",    1'b1);
    cyc(mk(1,0,0,0,0,0,0,0,1,0,0,0, O_XF,   4), "b2_xfer",   1'b1);
    cyc(mk(1,0,0,0,0,0,0,0,0,0,0,0, O_IDLE, 4), "b2_run",    1'b1);
    for (int i = 0; i < 20; i++)
      cyc(mk(1,0,0,0,0,0,0,0,0,1,0,0, O_FRZ, ((4 + i) > 15) ? 15 : (4 + i)),
          $sformatf("sat%0d", i), 1'b1);
    cyc(mk(1,1,0,0,0,0,0,0,0,1,0,0, O_IDLE, 15), "sat_rel",  1'b1);
    cyc(mk(1,0,0,0,0,0,0,0,0,0,0,0, O_IDLE, 15), "sat_hold", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
